finalprojsoc_pio_in_irq: RTL and testbench
==========================================

Name: finalprojsoc_pio_in_irq

Overview:
- Avalon-MM slave input port with edge capture and interrupt generation. It is the read-side counterpart of the SoC output PIO registers such as the USB reset/control outputs.
- Samples external input pins (USB IRQ/GPX-style status lines) through a synchronizer and latches edges into sticky bits. Drives a level IRQ to the Nios II interrupt controller.
- Software reads pin state, masks interrupts and clears captured edges over the same 2-bit address s1 interface as the output PIOs.

Parameters:
- WIDTH, 8: number of input pins (1..32).
- EDGE_TYPE, 0: edge sense; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchronizer flop depth (2..4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  register select
- chipselect  in  1  slave select
- read_n  in  1  read strobe, active-low
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data
- readdata  out  32  read data, registered
- in_port  in  WIDTH  asynchronous external pins
- irq  out  1  level interrupt to CPU

Behaviour:
- Clock and reset: clk, single clock domain. reset_n is asynchronous, active-low.
- Reset values, all zero: readdata, irq, irqmask, edgecapture, synchronizer chain, previous-sample register, warm-up counter.
- Synchronizer:
  - in_port passes through SYNC_STAGES flops to give sync_in.
  - prev_in is sync_in delayed by 1 cycle.
  - Pin change to sync_in takes SYNC_STAGES cycles.
- Edge detect, per bit:
  - rising = sync_in & ~prev_in
  - falling = ~sync_in & prev_in
  - any = rising | falling
  - Selected by EDGE_TYPE.
- Warm-up FSM:
  - States WARM and RUN. After reset release, a counter runs SYNC_STAGES+1 cycles in WARM, then the FSM enters RUN.
  - Edge detection is gated off in WARM. A pin held high through reset never produces a spurious rising capture.
  - The FSM stays in RUN until reset.
- Register map (writes take effect only when chipselect=1 and write_n=0):
  - Address 0, DATA: RO, returns zero-extended sync_in. Writes are ignored.
  - Address 1: reserved. Reads return 0; writes are ignored.
  - Address 2, IRQMASK: RW, WIDTH bits. Upper writedata bits are ignored.
  - Address 3, EDGECAPTURE: read returns the sticky bits. Write behaviour is set by the optional feature.
- Capture: bit n sets on a detected edge and holds until cleared by software.
- Edge vs clear in the same cycle on the same bit: the edge wins and the bit stays 1.
- Read timing:
  - readdata is registered: value appears the cycle after chipselect=1 and read_n=0 (read latency 1).
  - readdata holds its value when no read is in progress.
  - A read of EDGECAPTURE does not clear it.
- IRQ:
  - irq = |(edgecapture & irqmask), registered, so it asserts 1 cycle after the capture bit sets.
  - Deasserts 1 cycle after the clear write or mask write.
- Unused readdata bits [31:WIDTH] are always 0.
- Reset mid-operation: all state returns to reset values immediately and the FSM re-enters WARM. Pending edges are lost.

Optional Feature:
- Macro PIO_EDGE_BITCLEAR_EN.
- Defined: a write to EDGECAPTURE clears only the bits where writedata[n]=1. Other bits hold.
- Undefined: any write to EDGECAPTURE clears all bits, regardless of writedata.
- Edge-wins priority applies in both modes.

Decomposition:
- Shared package finalprojsoc_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - Edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY.
  - Warm-up FSM state enum.
- One natural sub-module, pio_sync_edge: per-vector synchronizer, prev register and edge detect, parameterised by WIDTH, SYNC_STAGES and EDGE_TYPE.
- Register file, FSM and IRQ logic stay in the top module.

Test Plan (WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2):
- in_port=8'hFF held through reset release, run 20 cycles -> EDGECAPTURE reads 8'h00, irq=0, DATA reads 32'h000000FF.
- Write IRQMASK=8'h05. After warm-up, pulse in_port[0] 0->1 -> EDGECAPTURE=8'h01; irq=1 exactly SYNC_STAGES+2 cycles after the pin change.
- Rising edge on in_port[1] with mask 8'h05 -> EDGECAPTURE bit1=1, irq stays 0. Write IRQMASK=8'h02 -> irq=1 next cycle.
- With PIO_EDGE_BITCLEAR_EN and EDGECAPTURE=8'h03, write 8'h01 -> reads 8'h02. Without the macro, the same write -> 8'h00.
- Clear write to EDGECAPTURE in the same cycle as a new edge on bit 0 -> bit0 remains 1, irq remains 1.
- Assert reset_n=0 mid-run with EDGECAPTURE=8'hAA -> readdata, irq and all registers read 0 after release; no capture during WARM.

Source files
------------

// File: rtl/finalprojsoc_pio_pkg.sv
// Shared constants and types for the finalprojsoc PIO input port: register
// addresses, edge-sense selectors and the warm-up FSM state encoding.
package finalprojsoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } warm_state_t;

endpackage

// File: rtl/pio_sync_edge.sv
// Per-vector input synchronizer, one-cycle history register and edge detector
// for the PIO input port.
module pio_sync_edge
    import finalprojsoc_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] rising;
    logic [WIDTH-1:0] falling;

    // synchronizer chain: sync_p[0] is the metastability-exposed stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
            prev_in <= '0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            prev_in <= sync_in;
        end
    end

    assign sync_in = sync_p[SYNC_STAGES-1];
    assign rising  = sync_in & ~prev_in;
    assign falling = ~sync_in & prev_in;

    always_comb begin
        edge_det = rising;
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = falling;
            EDGE_ANY:  edge_det = rising | falling;
            default:   edge_det = rising;
        endcase
    end

endmodule

// File: rtl/finalprojsoc_pio_in_irq.sv
// Avalon-MM PIO input port with sticky edge capture and level IRQ.
// Define PIO_EDGE_BITCLEAR_EN for per-bit clearing of EDGECAPTURE.
module finalprojsoc_pio_in_irq
    import finalprojsoc_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(SYNC_STAGES);

    warm_state_t      state, state_nx;
    logic [CNT_W-1:0] warm_cnt, warm_cnt_nx;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_run;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    // warm-up: hold off edge detection until the chain and prev_in hold real pin data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WARM;
            warm_cnt <= '0;
        end else begin
            state    <= state_nx;
            warm_cnt <= warm_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        warm_cnt_nx = warm_cnt;
        case (state)
            WARM: begin
                if (warm_cnt == WARM_LAST) begin
                    state_nx = RUN;
                end else begin
                    warm_cnt_nx = warm_cnt + CNT_W'(1);
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign edge_run = (state == RUN) ? edge_det : '0;
    assign wr_en    = chipselect && !write_n;
    assign rd_en    = chipselect && !read_n;

`ifdef PIO_EDGE_BITCLEAR_EN
    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
`else
    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? {WIDTH{1'b1}} : '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    // register file; a new edge overrides a same-cycle clear on its bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~cap_clr) | edge_run;
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq <= |(edgecapture & irqmask);
        end
    end

    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_finalprojsoc_pio_in_irq.sv
// Bench for finalprojsoc_pio_in_irq (WIDTH=8, rising edge, 2 sync stages):
// directed register/IRQ scenarios plus a cycle-level reference model.
module tb_finalprojsoc_pio_in_irq;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int ET = 0;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         read_n;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    finalprojsoc_pio_in_irq #(
        .WIDTH       (W),
        .EDGE_TYPE   (ET),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pin history buffer, cycles-since-reset counter, sticky capture word
    logic [W-1:0] m_hist [0:S];
    int           m_cnt;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap;
    logic [31:0]  m_rd;
    logic         m_irq;

    initial begin
        logic [W-1:0] sy, pr, ed, clr;
        for (int i = 0; i <= S; i++) m_hist[i] = '0;
        m_cnt = 0; m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int i = 0; i <= S; i++) m_hist[i] = '0;
                m_cnt = 0; m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
            end else begin
                sy = m_hist[S-1];
                pr = m_hist[S];
                case (ET)
                    1:       ed = ~sy & pr;
                    2:       ed = sy ^ pr;
                    default: ed = sy & ~pr;
                endcase
                if (m_cnt < S + 1) ed = '0;
                if (chipselect && !read_n) begin
                    m_rd = '0;
                    if (address == 2'd0) m_rd[W-1:0] = sy;
                    if (address == 2'd2) m_rd[W-1:0] = m_mask;
                    if (address == 2'd3) m_rd[W-1:0] = m_cap;
                end
                m_irq = |(m_cap & m_mask);
                clr = '0;
                if (chipselect && !write_n && address == 2'd3) begin
`ifdef PIO_EDGE_BITCLEAR_EN
                    clr = writedata[W-1:0];
`else
                    clr = '1;
`endif
                end
                m_cap = (m_cap & ~clr) | ed;
                if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
                for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = in_port;
                if (m_cnt < S + 1) m_cnt++;
            end
            #2;
            check("model_readdata", readdata, m_rd);
            check("model_irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name, input bit chk);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        if (chk) check(name, readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] exp_partial;

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = 8'hFF;
        idle(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        idle(20);

        // pins high through reset must not look like rising edges
        bus_read(2'd3, 32'h00, "warm_edgecap", 1'b1);
        check("warm_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd0, 32'h000000FF, "data_ff", 1'b1);
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFFFFFF);
        bus_read(2'd1, 32'h0, "reserved_read", 1'b1);
        bus_read(2'd0, 32'h000000FF, "data_ro", 1'b1);

        @(negedge clk); in_port = 8'h00;
        idle(6);
        bus_read(2'd3, 32'h00, "falling_ignored", 1'b1);
        bus_write(2'd2, 32'hFFFFFF05);
        bus_read(2'd2, 32'h05, "irqmask_rd", 1'b1);

        // irq latency from pin change
        @(negedge clk); in_port = 8'h01;
        repeat (3) @(posedge clk);
        #2 check("irq_lat_early", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #2 check("irq_lat_exact", {31'b0, irq}, 32'h1);
        bus_read(2'd3, 32'h01, "cap_bit0", 1'b1);

        bus_write(2'd3, 32'h01);
        idle(2);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(2'd3, 32'h00, "cap_cleared", 1'b1);

        @(negedge clk); in_port = 8'h03;
        idle(6);
        bus_read(2'd3, 32'h02, "cap_bit1", 1'b1);
        check("irq_masked", {31'b0, irq}, 32'h0);

        @(negedge clk);
        address = 2'd2; writedata = 32'h02; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #2 check("mask_irq_same", {31'b0, irq}, 32'h0);
        @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
        @(posedge clk);
        #2 check("mask_irq_next", {31'b0, irq}, 32'h1);

        @(negedge clk); in_port = 8'h02;
        idle(6);
        @(negedge clk); in_port = 8'h03;
        idle(6);
        bus_read(2'd3, 32'h03, "cap_03", 1'b1);
        bus_write(2'd3, 32'h01);
`ifdef PIO_EDGE_BITCLEAR_EN
        exp_partial = 32'h02;
`else
        exp_partial = 32'h00;
`endif
        bus_read(2'd3, exp_partial, "partial_clear", 1'b1);

        // clear write lands on the same edge that captures bit 0
        bus_write(2'd2, 32'h03);
        @(negedge clk); in_port = 8'h02;
        idle(6);
        @(negedge clk); in_port = 8'h03;
        @(negedge clk);
        @(negedge clk);
        address = 2'd3; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
        bus_read(2'd3, 32'h01, "edge_wins", 1'b1);
        check("edge_wins_irq", {31'b0, irq}, 32'h1);

        bus_write(2'd3, 32'hFF);
        @(negedge clk); in_port = 8'h01;
        idle(6);
        @(negedge clk); in_port = 8'hAB;
        idle(6);
        bus_read(2'd3, 32'hAA, "cap_aa", 1'b1);
        bus_write(2'd2, 32'hFF);
        idle(2);
        check("irq_aa", {31'b0, irq}, 32'h1);
        bus_read(2'd3, 32'hAA, "read_no_clear", 1'b1);

        // asynchronous reset mid-run
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(12);
        bus_read(2'd3, 32'h00, "post_reset_cap", 1'b1);
        bus_read(2'd2, 32'h00, "post_reset_mask", 1'b1);
        check("post_reset_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd0, 32'h000000AB, "post_reset_data", 1'b1);

        bus_write(2'd2, 32'h0F);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); in_port = W'($urandom);
            idle(2);
            if (i % 5 == 4) bus_read(2'd3, 32'h0, "", 1'b0);
            if (i % 7 == 6) bus_write(2'd3, $urandom);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
